// File: rtl/pipe_ctrl.sv
// Pipeline-register bank with stall/flush/valid handling and load-use bubble insertion.
// Optional performance counters are built only when PIPE_CTRL_PERF_CNT_EN is defined.
module pipe_ctrl #(
  parameter int NUM_STAGES = 4,
  parameter int PAYLOAD_W  = 128,
  parameter int REG_ADDR_W = 5
) (
  input  logic                            clk,
  input  logic                            arst_n,
  input  logic                            in_valid,
  input  logic [NUM_STAGES*PAYLOAD_W-1:0] stage_in,
  output logic [NUM_STAGES*PAYLOAD_W-1:0] stage_out,
  output logic [NUM_STAGES-1:0]           stage_valid,
  input  logic [REG_ADDR_W-1:0]           id_rs1,
  input  logic [REG_ADDR_W-1:0]           id_rs2,
  input  logic                            id_use_rs1,
  input  logic                            id_use_rs2,
  input  logic [REG_ADDR_W-1:0]           ex_rd,
  input  logic                            ex_is_load,
  input  logic                            flush,
  input  logic                            ext_stall,
  output logic                            pc_en,
  output logic                            hazard,
  output logic [31:0]                     perf_stall_cnt,
  output logic [31:0]                     perf_bubble_cnt,
  output logic [31:0]                     perf_flush_cnt
);

  logic [NUM_STAGES*PAYLOAD_W-1:0] payload_p1, payload_d;
  logic [NUM_STAGES-1:0]           vld_p1, vld_d;
  logic [NUM_STAGES-1:0]           vld_prev;
  logic                            hazard_run;

  // Hazard is reported raw; it only acts when neither flush nor ext_stall outranks it.
  assign hazard = vld_p1[0] & vld_p1[1] & ex_is_load & (ex_rd != '0) &
                  ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  assign hazard_run = hazard & ~flush & ~ext_stall;
  assign pc_en      = flush | ~(ext_stall | hazard);

  assign vld_prev = {vld_p1[NUM_STAGES-2:0], in_valid};

  always_comb begin
    payload_d = payload_p1;
    vld_d     = vld_p1;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if ((flush && k < 2) || (hazard_run && k == 1)) begin
        payload_d[k*PAYLOAD_W +: PAYLOAD_W] = '0;
        vld_d[k]                            = 1'b0;
      end else if (!(ext_stall || (hazard_run && k == 0))) begin
        payload_d[k*PAYLOAD_W +: PAYLOAD_W] = stage_in[k*PAYLOAD_W +: PAYLOAD_W];
        vld_d[k]                            = vld_prev[k];
      end
    end
  end

  // Boundary registers p1
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      payload_p1 <= '0;
      vld_p1     <= '0;
    end else begin
      payload_p1 <= payload_d;
      vld_p1     <= vld_d;
    end
  end

  assign stage_out   = payload_p1;
  assign stage_valid = vld_p1;

`ifdef PIPE_CTRL_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  logic [31:0] stall_cnt_p1, bubble_cnt_p1, flush_cnt_p1;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt_p1  <= '0;
      bubble_cnt_p1 <= '0;
      flush_cnt_p1  <= '0;
    end else begin
      stall_cnt_p1  <= sat_inc(stall_cnt_p1, ext_stall & ~flush);
      bubble_cnt_p1 <= sat_inc(bubble_cnt_p1, hazard_run);
      flush_cnt_p1  <= sat_inc(flush_cnt_p1, flush);
    end
  end

  assign perf_stall_cnt  = stall_cnt_p1;
  assign perf_bubble_cnt = bubble_cnt_p1;
  assign perf_flush_cnt  = flush_cnt_p1;
`else
  assign perf_stall_cnt  = '0;
  assign perf_bubble_cnt = '0;
  assign perf_flush_cnt  = '0;
`endif

endmodule
